bresenham_3d: RTL and testbench

Three-axis integer line interpolator for the 3D motion controller. It accepts a start and end point in signed XYZ coordinates and emits every lattice point of the Bresenham line, one point per accepted handshake. It sits between the trajectory planner, which loads segments, and the stepper/actuator interface, which consumes points with backpressure. It succeeds the 2D interpolator with these additions: a generic coordinate width, a third axis, a valid/ack output handshake, abort, and a completion pulse.

---
 rtl/bresenham_3d.sv | 174 +++++++++++++++++
 tb/tb_bresenham_3d.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bresenham_3d.sv
// rtl/bresenham_3d.sv - three-axis Bresenham line interpolator with valid/ack point output
// Optional feature macro: BRESENHAM3D_STEP_DIR_EN adds registered o_step/o_dir outputs.
module bresenham_3d #(
  parameter int P_COORD_W = 16
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic signed [P_COORD_W-1:0] i_x0,
  input  logic signed [P_COORD_W-1:0] i_y0,
  input  logic signed [P_COORD_W-1:0] i_z0,
  input  logic signed [P_COORD_W-1:0] i_x1,
  input  logic signed [P_COORD_W-1:0] i_y1,
  input  logic signed [P_COORD_W-1:0] i_z1,
  input  logic                        i_load_vals,
  input  logic                        i_abort,
  input  logic                        i_vals_ack,
  output logic signed [P_COORD_W-1:0] o_x_val,
  output logic signed [P_COORD_W-1:0] o_y_val,
  output logic signed [P_COORD_W-1:0] o_z_val,
  output logic                        o_vals_rdy,
  output logic                        o_waiting,
  output logic                        o_done
`ifdef BRESENHAM3D_STEP_DIR_EN
  ,
  output logic [2:0]                  o_step,
  output logic [2:0]                  o_dir
`endif
);

  localparam int P_ERR_W = P_COORD_W + 3;
  localparam int DW = P_COORD_W + 1;
  localparam logic [P_COORD_W-1:0] ONE = P_COORD_W'(1);

  typedef enum logic [1:0] {IDLE, DELTA, AXIS, STEP} state_t;
  state_t state;

  // Per-axis vectors, index 0 = x, 1 = y, 2 = z
  logic [2:0][P_COORD_W-1:0] p0, p1, cur;
  logic [2:0][DW-1:0]        ad;
  logic [2:0]                neg;
  logic [2:0][P_ERR_W-1:0]   err;
  logic [DW-1:0]             dm, count;
  logic [1:0]                major;
  logic [1:0]                major_c;
  logic [DW-1:0]             dm_c;

  function automatic logic [DW-1:0] abs_diff(input logic [P_COORD_W-1:0] a,
                                             input logic [P_COORD_W-1:0] b);
    logic [DW-1:0] d;
    d = {b[P_COORD_W-1], b} - {a[P_COORD_W-1], a};
    return d[DW-1] ? -d : d;
  endfunction

  function automatic logic [P_ERR_W-1:0] twice(input logic [DW-1:0] v);
    return {1'b0, v, 1'b0};
  endfunction

  // Ties resolve X over Y over Z
  always_comb begin
    major_c = 2'd0;
    dm_c    = ad[0];
    if (ad[0] >= ad[1] && ad[0] >= ad[2]) begin
      major_c = 2'd0;
      dm_c    = ad[0];
    end else if (ad[1] >= ad[2]) begin
      major_c = 2'd1;
      dm_c    = ad[1];
    end else begin
      major_c = 2'd2;
      dm_c    = ad[2];
    end
  end

  assign o_waiting = (state == IDLE);
  assign o_x_val   = cur[0];
  assign o_y_val   = cur[1];
  assign o_z_val   = cur[2];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      p0         <= '0;
      p1         <= '0;
      cur        <= '0;
      ad         <= '0;
      neg        <= '0;
      err        <= '0;
      dm         <= '0;
      count      <= '0;
      major      <= '0;
      o_vals_rdy <= 1'b0;
      o_done     <= 1'b0;
`ifdef BRESENHAM3D_STEP_DIR_EN
      o_step     <= '0;
      o_dir      <= '0;
`endif
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_load_vals) begin
            p0    <= {i_z0, i_y0, i_x0};
            p1    <= {i_z1, i_y1, i_x1};
            state <= DELTA;
          end
        end
        DELTA: begin
          if (i_abort) begin
            state <= IDLE;
          end else begin
            for (int a = 0; a < 3; a++) begin
              ad[a]  <= abs_diff(p0[a], p1[a]);
              neg[a] <= $signed(p1[a]) < $signed(p0[a]);
            end
            state <= AXIS;
          end
        end
        AXIS: begin
          if (i_abort) begin
            state <= IDLE;
          end else begin
            major <= major_c;
            dm    <= dm_c;
            count <= dm_c;
            for (int a = 0; a < 3; a++)
              err[a] <= twice(ad[a]) - {2'b00, dm_c};
            state <= STEP;
          end
        end
        STEP: begin
          if (i_abort) begin
            o_vals_rdy <= 1'b0;
            state      <= IDLE;
          end else if (o_done) begin
            // Completion cycle: still busy so a load seen alongside o_done is dropped
            state <= IDLE;
          end else if (!o_vals_rdy) begin
            cur        <= p0;
            o_vals_rdy <= 1'b1;
`ifdef BRESENHAM3D_STEP_DIR_EN
            o_step     <= '0;
            o_dir      <= '0;
`endif
          end else if (i_vals_ack) begin
            if (count == '0) begin
              o_vals_rdy <= 1'b0;
              o_done     <= 1'b1;
            end else begin
              count <= count - DW'(1);
              for (int a = 0; a < 3; a++) begin
                if (2'(a) == major || !err[a][P_ERR_W-1])
                  cur[a] <= neg[a] ? cur[a] - ONE : cur[a] + ONE;
                if (2'(a) != major) begin
                  if (!err[a][P_ERR_W-1])
                    err[a] <= err[a] - twice(dm) + twice(ad[a]);
                  else
                    err[a] <= err[a] + twice(ad[a]);
                end
`ifdef BRESENHAM3D_STEP_DIR_EN
                o_step[a] <= (2'(a) == major) || !err[a][P_ERR_W-1];
`endif
              end
`ifdef BRESENHAM3D_STEP_DIR_EN
              o_dir <= neg;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bresenham_3d.sv
// tb/tb_bresenham_3d.sv - randomized self-checking bench for bresenham_3d
// Reference uses the closed form offset_i = round_half_up(i*|da|/dm) per axis.
module tb_bresenham_3d;

  logic i_clk = 1'b0;
  logic i_reset_n;
  logic signed [15:0] i_x0, i_y0, i_z0, i_x1, i_y1, i_z1;
  logic i_load_vals, i_abort, i_vals_ack;
  logic signed [15:0] o_x_val, o_y_val, o_z_val;
  logic o_vals_rdy, o_waiting, o_done;
`ifdef BRESENHAM3D_STEP_DIR_EN
  logic [2:0] o_step, o_dir;
`endif

  always #5 i_clk = ~i_clk;

  bresenham_3d #(.P_COORD_W(16)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_x0(i_x0), .i_y0(i_y0), .i_z0(i_z0),
    .i_x1(i_x1), .i_y1(i_y1), .i_z1(i_z1),
    .i_load_vals(i_load_vals), .i_abort(i_abort), .i_vals_ack(i_vals_ack),
    .o_x_val(o_x_val), .o_y_val(o_y_val), .o_z_val(o_z_val),
    .o_vals_rdy(o_vals_rdy), .o_waiting(o_waiting), .o_done(o_done)
`ifdef BRESENHAM3D_STEP_DIR_EN
    , .o_step(o_step), .o_dir(o_dir)
`endif
  );

  typedef logic [2:0][15:0] vec_t;
  typedef struct packed {
    logic [15:0] x, y, z;
    logic [2:0]  st, dr;
  } pt_t;

  pt_t obs[$];
  pt_t expq[$];
  int  checks = 0;
  int  failures = 0;
  int  first_lat, done_cyc, n_done;
  bit  timed_out, stall_bad;
  logic done_twice, waiting_after, rdy_after_abort, done_after_abort, waiting_after_abort;
  pt_t pt_after;

  function automatic vec_t mk(input int x, input int y, input int z);
    return {16'(z), 16'(y), 16'(x)};
  endfunction

  function automatic pt_t dut_pt();
    pt_t p;
    p.x = o_x_val; p.y = o_y_val; p.z = o_z_val;
    p.st = 3'b000; p.dr = 3'b000;
`ifdef BRESENHAM3D_STEP_DIR_EN
    p.st = o_step; p.dr = o_dir;
`endif
    return p;
  endfunction

  task automatic model(input vec_t s, input vec_t e, input int max_pts);
    longint d[3], sg[3], c[3], pc[3], dm;
    pt_t p;
    expq.delete();
    dm = 0;
    for (int a = 0; a < 3; a++) begin
      d[a]  = longint'($signed(e[a])) - longint'($signed(s[a]));
      sg[a] = (d[a] < 0) ? -1 : 1;
      if (d[a] < 0) d[a] = -d[a];
      if (d[a] > dm) dm = d[a];
    end
    for (longint i = 0; i <= dm && i < max_pts; i++) begin
      for (int a = 0; a < 3; a++)
        c[a] = longint'($signed(s[a])) + sg[a] * ((dm == 0) ? 0 : (2 * i * d[a] + dm) / (2 * dm));
      p.x = 16'(c[0]); p.y = 16'(c[1]); p.z = 16'(c[2]);
      p.st = 3'b000; p.dr = 3'b000;
`ifdef BRESENHAM3D_STEP_DIR_EN
      if (i > 0) begin
        p.st = {c[2] != pc[2], c[1] != pc[1], c[0] != pc[0]};
        p.dr = {sg[2] < 0, sg[1] < 0, sg[0] < 0};
      end
`endif
      pc = c;
      expq.push_back(p);
    end
  endtask

  // Drives one segment and records what the DUT emitted; comparisons happen in the test tasks
  task automatic run_seg(input vec_t s, input vec_t e, input int stall_idx, input int stall_len,
                         input int abort_idx, input bit glitch, input bit rnd_ack,
                         input bit load_on_done, input int max_cyc);
    int cyc, k, stall_cnt;
    bit ack, aborted, glitched, glitch_on;
    pt_t p, held;
    obs.delete();
    first_lat = -1; done_cyc = -1; n_done = 0; timed_out = 0; stall_bad = 0;
    stall_cnt = 0; aborted = 0; glitched = 0; glitch_on = 0;
    done_twice = 1'bx; waiting_after = 1'bx;
    for (int w = 0; w < 20 && !o_waiting; w++) begin
      @(posedge i_clk); #1;
    end
    {i_z0, i_y0, i_x0} = s;
    {i_z1, i_y1, i_x1} = e;
    i_load_vals = 1'b1; i_vals_ack = 1'b0; i_abort = 1'b0;
    @(posedge i_clk); #1;
    i_load_vals = 1'b0;
    cyc = 0;
    while (1) begin
      @(posedge i_clk); #1;
      cyc++;
      if (glitch_on) begin i_load_vals = 1'b0; glitch_on = 0; end
      if (done_cyc >= 0) begin
        done_twice = o_done; waiting_after = o_waiting; pt_after = dut_pt();
        i_load_vals = 1'b0;
        break;
      end
      if (aborted) begin
        rdy_after_abort = o_vals_rdy; done_after_abort = o_done; waiting_after_abort = o_waiting;
        i_abort = 1'b0;
        break;
      end
      if (o_done) begin
        n_done++; done_cyc = cyc; i_vals_ack = 1'b0;
        if (load_on_done) begin
          {i_z0, i_y0, i_x0} = mk(11, -11, 7);
          {i_z1, i_y1, i_x1} = mk(-3, 2, 9);
          i_load_vals = 1'b1;
        end
        continue;
      end
      if (cyc > max_cyc) begin timed_out = 1; break; end
      ack = rnd_ack ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_vals_rdy) begin
        if (first_lat < 0) first_lat = cyc;
        k = obs.size();
        p = dut_pt();
        if (k == stall_idx && stall_cnt < stall_len) begin
          if (stall_cnt > 0 && p !== held) stall_bad = 1;
          held = p; stall_cnt++; ack = 1'b0;
        end
        if (k == abort_idx) begin
          i_abort = 1'b1; ack = 1'b1; aborted = 1;
        end else if (ack) begin
          obs.push_back(p);
        end
        if (glitch && k == 1 && !glitched) begin
          {i_z0, i_y0, i_x0} = mk(-7, 9, 3);
          {i_z1, i_y1, i_x1} = mk(20, -20, 1);
          i_load_vals = 1'b1; glitch_on = 1; glitched = 1;
        end
      end
      i_vals_ack = ack;
    end
    i_vals_ack = 1'b0; i_abort = 1'b0; i_load_vals = 1'b0;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0; i_load_vals = 1'b0; i_abort = 1'b0; i_vals_ack = 1'b0;
    {i_x0, i_y0, i_z0, i_x1, i_y1, i_z1} = '0;
    @(posedge i_clk); #1;
    checks++;
    if ({o_x_val, o_y_val, o_z_val} !== 48'd0) begin
      failures++; $display("FAIL reset_vals got=%h exp=0", {o_x_val, o_y_val, o_z_val});
    end
    checks++;
    if ({o_vals_rdy, o_done, o_waiting} !== 3'b001) begin
      failures++; $display("FAIL reset_flags got=%b exp=001", {o_vals_rdy, o_done, o_waiting});
    end
    i_reset_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_basic(input string nm, input vec_t s, input vec_t e);
    model(s, e, 1 << 20);
    run_seg(s, e, -1, 0, -1, 0, 0, 0, 200);
    checks++;
    if (timed_out) begin failures++; $display("FAIL %s_timeout got=1 exp=0", nm); end
    checks++;
    if (first_lat != 3) begin failures++; $display("FAIL %s_latency got=%0d exp=3", nm, first_lat); end
    checks++;
    if (obs.size() != expq.size()) begin
      failures++; $display("FAIL %s_count got=%0d exp=%0d", nm, obs.size(), expq.size());
    end else begin
      foreach (expq[i]) begin
        checks++;
        if (obs[i] !== expq[i]) begin
          failures++; $display("FAIL %s_pt%0d got=%h exp=%h", nm, i, obs[i], expq[i]);
        end
      end
    end
    checks++;
    if (n_done != 1 || done_cyc != 3 + expq.size()) begin
      failures++; $display("FAIL %s_done got=%0d@%0d exp=1@%0d", nm, n_done, done_cyc, 3 + expq.size());
    end
    checks++;
    if (done_twice !== 1'b0 || waiting_after !== 1'b1) begin
      failures++; $display("FAIL %s_after_done got=%b%b exp=01", nm, done_twice, waiting_after);
    end
    checks++;
    if (pt_after.x !== expq[$].x || pt_after.y !== expq[$].y || pt_after.z !== expq[$].z) begin
      failures++; $display("FAIL %s_hold got=%h exp=%h", nm, pt_after, expq[$]);
    end
  endtask

  task automatic test_directed();
    test_basic("line", mk(0, 0, 0), mk(4, 2, 1));
    checks++;
    if (obs.size() == 5 && {obs[2].x, obs[2].y, obs[2].z} !== {16'd2, 16'd1, 16'd1}) begin
      failures++; $display("FAIL line_literal got=%h exp=000200010001", {obs[2].x, obs[2].y, obs[2].z});
    end
    test_basic("tie", mk(3, -1, 0), mk(0, -1, -3));
    test_basic("zero", mk(5, 5, 5), mk(5, 5, 5));
    test_basic("wide", mk(-32768, 0, 32767), mk(-32760, -5, 32759));
  endtask

  task automatic test_stall();
    model(mk(0, 0, 0), mk(4, 2, 1), 100);
    run_seg(mk(0, 0, 0), mk(4, 2, 1), 1, 4, -1, 0, 0, 0, 200);
    checks++;
    if (stall_bad) begin failures++; $display("FAIL stall_hold got=changed exp=stable"); end
    checks++;
    if (obs.size() != expq.size()) begin
      failures++; $display("FAIL stall_count got=%0d exp=%0d", obs.size(), expq.size());
    end else begin
      foreach (expq[i]) begin
        checks++;
        if (obs[i] !== expq[i]) begin
          failures++; $display("FAIL stall_pt%0d got=%h exp=%h", i, obs[i], expq[i]);
        end
      end
    end
    checks++;
    if (done_cyc != 3 + 5 + 4) begin failures++; $display("FAIL stall_done_cyc got=%0d exp=12", done_cyc); end
  endtask

  task automatic test_abort();
    model(mk(0, 0, 0), mk(4, 2, 1), 2);
    run_seg(mk(0, 0, 0), mk(4, 2, 1), -1, 0, 2, 0, 0, 0, 200);
    checks++;
    if (obs.size() != 2 || obs[0] !== expq[0] || obs[1] !== expq[1]) begin
      failures++; $display("FAIL abort_pts got=%0d exp=2", obs.size());
    end
    checks++;
    if ({rdy_after_abort, done_after_abort, waiting_after_abort} !== 3'b001 || n_done != 0) begin
      failures++; $display("FAIL abort_flags got=%b%b%b exp=001", rdy_after_abort, done_after_abort, waiting_after_abort);
    end
    test_basic("after_abort", mk(-2, 6, 1), mk(3, 4, -6));
  endtask

  task automatic test_load_ignored();
    model(mk(0, 0, 0), mk(4, 2, 1), 100);
    run_seg(mk(0, 0, 0), mk(4, 2, 1), -1, 0, -1, 1, 0, 1, 200);
    checks++;
    if (obs.size() != expq.size()) begin
      failures++; $display("FAIL glitch_count got=%0d exp=%0d", obs.size(), expq.size());
    end else begin
      foreach (expq[i]) begin
        checks++;
        if (obs[i] !== expq[i]) begin
          failures++; $display("FAIL glitch_pt%0d got=%h exp=%h", i, obs[i], expq[i]);
        end
      end
    end
    checks++;
    if (waiting_after !== 1'b1 || n_done != 1) begin
      failures++; $display("FAIL load_on_done got=%b exp=1", waiting_after);
    end
  endtask

  task automatic test_random();
    vec_t s, e;
    int lim;
    for (int n = 0; n < 44; n++) begin
      for (int a = 0; a < 3; a++) begin
        if (n < 40) begin
          s[a] = 16'($urandom_range(0, 40) - 20);
          e[a] = 16'($urandom_range(0, 40) - 20);
        end else begin
          s[a] = 16'($urandom);
          e[a] = 16'($urandom);
        end
      end
      lim = (n < 40) ? (1 << 20) : 12;
      model(s, e, lim);
      run_seg(s, e, -1, 0, (n < 40) ? -1 : 12, 0, 1, 0, 2000);
      checks++;
      if (timed_out || obs.size() != expq.size()) begin
        failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", n, obs.size(), expq.size());
      end else begin
        foreach (expq[i]) begin
          checks++;
          if (obs[i] !== expq[i]) begin
            failures++; $display("FAIL rand%0d_pt%0d got=%h exp=%h", n, i, obs[i], expq[i]);
          end
        end
      end
      if (n < 40) begin
        checks++;
        if (n_done != 1) begin failures++; $display("FAIL rand%0d_done got=%0d exp=1", n, n_done); end
      end
    end
  endtask

  task automatic test_reset_mid();
    {i_z0, i_y0, i_x0} = mk(1, 2, 3);
    {i_z1, i_y1, i_x1} = mk(9, 8, 7);
    i_load_vals = 1'b1;
    @(posedge i_clk); #1;
    i_load_vals = 1'b0; i_vals_ack = 1'b1;
    repeat (5) begin @(posedge i_clk); #1; end
    i_reset_n = 1'b0;
    #1;
    checks++;
    if ({o_x_val, o_y_val, o_z_val} !== 48'd0 || {o_vals_rdy, o_done, o_waiting} !== 3'b001) begin
      failures++; $display("FAIL reset_mid got=%h/%b exp=0/001", {o_x_val, o_y_val, o_z_val}, {o_vals_rdy, o_done, o_waiting});
    end
    i_vals_ack = 1'b0;
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_abort();
    test_load_ignored();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
